// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier: one conditional add and one right shift per cycle.
// Operands and the 2*WIDTH-bit product each cross their own valid/ready handshake.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 Zero,
  output logic [1:0]           o_dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is high only in IDLE, out_valid only in DONE, so the
  // two sides never overlap and valid never depends on the partner's ready.
  state_t                r_state;
  state_t                w_next_state;
  logic [WIDTH-1:0]      r_mcand;
  logic [2*WIDTH-1:0]    r_acc;
  logic [CW-1:0]         r_cnt;
  logic [2*WIDTH-1:0]    r_product;
  logic                  r_zero;

  logic [WIDTH-1:0]      w_addend;
  logic [WIDTH:0]        w_sum;
  logic [2*WIDTH-1:0]    w_acc_next;
  logic                  w_last;

  // The carry out of the upper-half add re-enters as the accumulator MSB.
  assign w_addend   = r_acc[0] ? r_mcand : '0;
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
  assign w_last     = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_zero    <= 1'b0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_mcand <= A;
      r_acc   <= {{WIDTH{1'b0}}, B};
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_product <= w_acc_next;
        r_zero    <= (w_acc_next == '0);
      end
    end
  end

  assign Product     = r_product;
  assign Zero        = r_zero;
  assign o_dbg_state = r_state;

endmodule
